// File: rtl/uart_rx_deframer.sv
// UART receiver: 2-FF synchroniser, mid-bit sampling, optional parity check,
// and a single-entry valid/ready output register with per-word error flags.
module uart_rx_deframer #(
   parameter int    CLK_FRAC   = 50,
   parameter int    BAUD       = 19200,
   parameter int    DATA_WIDTH = 8,
   parameter string CHECK_BIT  = "none"
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  uart_rxd,
   input  logic                  i_user_rx_ready,
   output logic                  o_user_rx_valid,
   output logic [DATA_WIDTH-1:0] o_user_rx_data,
   output logic                  o_user_rx_perr,
   output logic                  o_user_rx_ferr,
   output logic                  o_user_rx_ovr
);

   localparam int LP_BIT_LEN = CLK_FRAC * 100000 / BAUD;
   localparam int LP_HALF    = LP_BIT_LEN / 2;
   localparam int CNT_W      = $clog2(LP_BIT_LEN + 1);
   localparam int IDX_W      = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

   localparam logic [CNT_W-1:0] HALF_M1  = CNT_W'(LP_HALF - 1);
   localparam logic [CNT_W-1:0] BIT_M1   = CNT_W'(LP_BIT_LEN - 1);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

   localparam bit HAS_PAR  = (CHECK_BIT != "none");
   localparam bit PAR_EVEN = (CHECK_BIT == "even");
   localparam bit PAR_ODD  = (CHECK_BIT == "odd");
   localparam bit PAR_MASK = (CHECK_BIT == "mask");

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4,
      BRK    = 3'd5
   } state_t;

   state_t                state, state_n;
   logic                  rxd_m, rxd_s;
   logic [CNT_W-1:0]      cnt, cnt_n;
   logic [IDX_W-1:0]      bit_idx, bit_idx_n;
   logic [DATA_WIDTH-1:0] shreg, shreg_n;
   logic [DATA_WIDTH:0]   shift_in;
   logic                  par_acc, par_acc_n;
   logic                  perr_pend, perr_pend_n;
   logic                  exp_par;
   logic                  tick;
   logic                  complete;

   logic                  valid_n;
   logic [DATA_WIDTH-1:0] data_n;
   logic                  perr_n, ferr_n, ovr_n;

   always_ff @(posedge clk) begin
      if (rst) begin
         rxd_m <= 1'b1;
         rxd_s <= 1'b1;
      end else begin
         rxd_m <= uart_rxd;
         rxd_s <= rxd_m;
      end
   end

   assign tick     = (cnt == '0);
   assign shift_in = {rxd_s, shreg};
   assign exp_par  = PAR_ODD  ? ~par_acc :
                     PAR_EVEN ?  par_acc :
                     PAR_MASK ?  1'b1    : 1'b0;

   always_comb begin
      state_n     = state;
      cnt_n       = cnt;
      bit_idx_n   = bit_idx;
      shreg_n     = shreg;
      par_acc_n   = par_acc;
      perr_pend_n = perr_pend;
      complete    = 1'b0;
      case (state)
         IDLE: begin
            if (!rxd_s) begin
               cnt_n       = HALF_M1;
               bit_idx_n   = '0;
               par_acc_n   = 1'b0;
               perr_pend_n = 1'b0;
               state_n     = START;
            end
         end
         START: begin
            if (!tick) begin
               cnt_n = cnt - CNT_W'(1);
            end else if (rxd_s) begin
               state_n = IDLE;
            end else begin
               cnt_n     = BIT_M1;
               bit_idx_n = '0;
               state_n   = DATA;
            end
         end
         DATA: begin
            if (!tick) begin
               cnt_n = cnt - CNT_W'(1);
            end else begin
               shreg_n   = shift_in[DATA_WIDTH:1];
               par_acc_n = par_acc ^ rxd_s;
               cnt_n     = BIT_M1;
               if (bit_idx == LAST_IDX) begin
                  state_n = HAS_PAR ? PARITY : STOP;
               end else begin
                  bit_idx_n = bit_idx + IDX_W'(1);
               end
            end
         end
         PARITY: begin
            if (!tick) begin
               cnt_n = cnt - CNT_W'(1);
            end else begin
               if (rxd_s != exp_par) perr_pend_n = 1'b1;
               cnt_n   = BIT_M1;
               state_n = STOP;
            end
         end
         STOP: begin
            if (!tick) begin
               cnt_n = cnt - CNT_W'(1);
            end else begin
               // Returning to IDLE at mid-stop lets a slightly fast sender's
               // next start edge be caught without losing a bit.
               complete = 1'b1;
               state_n  = rxd_s ? IDLE : BRK;
            end
         end
         BRK: begin
            if (rxd_s) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   // Output handshake: o_user_rx_valid holds with data/flags stable until a
   // cycle with i_user_rx_ready=1, then drops the next cycle. A word that
   // completes while valid=1 and ready=0 overwrites the held one and pulses
   // o_user_rx_ovr; completion in the accepting cycle simply reloads.
   always_comb begin
      valid_n = o_user_rx_valid;
      data_n  = o_user_rx_data;
      perr_n  = o_user_rx_perr;
      ferr_n  = o_user_rx_ferr;
      ovr_n   = 1'b0;
      if (o_user_rx_valid && i_user_rx_ready) valid_n = 1'b0;
      if (complete) begin
         valid_n = 1'b1;
         data_n  = shreg;
         perr_n  = perr_pend;
         ferr_n  = !rxd_s;
         ovr_n   = o_user_rx_valid && !i_user_rx_ready;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state           <= IDLE;
         cnt             <= '0;
         bit_idx         <= '0;
         shreg           <= '0;
         par_acc         <= 1'b0;
         perr_pend       <= 1'b0;
         o_user_rx_valid <= 1'b0;
         o_user_rx_data  <= '0;
         o_user_rx_perr  <= 1'b0;
         o_user_rx_ferr  <= 1'b0;
         o_user_rx_ovr   <= 1'b0;
      end else begin
         state           <= state_n;
         cnt             <= cnt_n;
         bit_idx         <= bit_idx_n;
         shreg           <= shreg_n;
         par_acc         <= par_acc_n;
         perr_pend       <= perr_pend_n;
         o_user_rx_valid <= valid_n;
         o_user_rx_data  <= data_n;
         o_user_rx_perr  <= perr_n;
         o_user_rx_ferr  <= ferr_n;
         o_user_rx_ovr   <= ovr_n;
      end
   end

endmodule

// File: tb/tb_uart_rx_deframer.sv
// Bench for uart_rx_deframer: three instances (no parity, even, odd) fed from
// one serial driver, with a per-instance expected-word queue.
`timescale 1ns/1ps
module tb_uart_rx_deframer;

   localparam int  CLK_FRAC = 50;
   localparam int  BAUD     = 500000;
   localparam real BIT_NS   = 100.0;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic line = 1'b1;
   int   sel = 0;
   logic rdy_none = 1'b1;
   logic rdy_par = 1'b1;

   logic rxd_none, rxd_even, rxd_odd;
   assign rxd_none = (sel == 0) ? line : 1'b1;
   assign rxd_even = (sel == 1) ? line : 1'b1;
   assign rxd_odd  = (sel == 2) ? line : 1'b1;

   logic       v_n, pe_n, fe_n, ov_n;
   logic [7:0] d_n;
   logic       v_e, pe_e, fe_e, ov_e;
   logic [7:0] d_e;
   logic       v_o, pe_o, fe_o, ov_o;
   logic [7:0] d_o;

   uart_rx_deframer #(.CLK_FRAC(CLK_FRAC), .BAUD(BAUD), .DATA_WIDTH(8), .CHECK_BIT("none")) dut_none (
      .clk(clk), .rst(rst), .uart_rxd(rxd_none), .i_user_rx_ready(rdy_none),
      .o_user_rx_valid(v_n), .o_user_rx_data(d_n), .o_user_rx_perr(pe_n),
      .o_user_rx_ferr(fe_n), .o_user_rx_ovr(ov_n));

   uart_rx_deframer #(.CLK_FRAC(CLK_FRAC), .BAUD(BAUD), .DATA_WIDTH(8), .CHECK_BIT("even")) dut_even (
      .clk(clk), .rst(rst), .uart_rxd(rxd_even), .i_user_rx_ready(rdy_par),
      .o_user_rx_valid(v_e), .o_user_rx_data(d_e), .o_user_rx_perr(pe_e),
      .o_user_rx_ferr(fe_e), .o_user_rx_ovr(ov_e));

   uart_rx_deframer #(.CLK_FRAC(CLK_FRAC), .BAUD(BAUD), .DATA_WIDTH(8), .CHECK_BIT("odd")) dut_odd (
      .clk(clk), .rst(rst), .uart_rxd(rxd_odd), .i_user_rx_ready(rdy_par),
      .o_user_rx_valid(v_o), .o_user_rx_data(d_o), .o_user_rx_perr(pe_o),
      .o_user_rx_ferr(fe_o), .o_user_rx_ovr(ov_o));

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int words_none = 0, words_even = 0, words_odd = 0;
   int ovr_none = 0, ovr_par = 0;

   // Expected word format: {ferr, perr, data}
   logic [9:0] exp_none[$];
   logic [9:0] exp_even[$];
   logic [9:0] exp_odd[$];

   task automatic monitor();
      logic [9:0] e;
      forever begin
         @(negedge clk);
         if (!rst) begin
            if (v_n && rdy_none) begin
               words_none++;
               checks++;
               if (exp_none.size() == 0) begin
                  errors++;
                  $display("FAIL sb_none unexpected word got=%h", {fe_n, pe_n, d_n});
               end else begin
                  e = exp_none.pop_front();
                  if ({fe_n, pe_n, d_n} !== e) begin
                     errors++;
                     $display("FAIL sb_none got=%h exp=%h", {fe_n, pe_n, d_n}, e);
                  end
               end
            end
            if (v_e && rdy_par) begin
               words_even++;
               checks++;
               if (exp_even.size() == 0) begin
                  errors++;
                  $display("FAIL sb_even unexpected word got=%h", {fe_e, pe_e, d_e});
               end else begin
                  e = exp_even.pop_front();
                  if ({fe_e, pe_e, d_e} !== e) begin
                     errors++;
                     $display("FAIL sb_even got=%h exp=%h", {fe_e, pe_e, d_e}, e);
                  end
               end
            end
            if (v_o && rdy_par) begin
               words_odd++;
               checks++;
               if (exp_odd.size() == 0) begin
                  errors++;
                  $display("FAIL sb_odd unexpected word got=%h", {fe_o, pe_o, d_o});
               end else begin
                  e = exp_odd.pop_front();
                  if ({fe_o, pe_o, d_o} !== e) begin
                     errors++;
                     $display("FAIL sb_odd got=%h exp=%h", {fe_o, pe_o, d_o}, e);
                  end
               end
            end
            if (ov_n) ovr_none++;
            if (ov_e || ov_o) ovr_par++;
         end
      end
   endtask

   task automatic send_frame(input logic [7:0] d, input bit has_par, input logic par,
                             input logic stop, input real bns);
      line = 1'b0;
      #(bns);
      for (int i = 0; i < 8; i++) begin
         line = d[i];
         #(bns);
      end
      if (has_par) begin
         line = par;
         #(bns);
      end
      line = stop;
      #(bns);
      line = 1'b1;
   endtask

   task automatic wait_drain(output bit ok);
      ok = 1'b0;
      for (int n = 0; n < 3000; n++) begin
         if (exp_none.size() == 0 && exp_even.size() == 0 && exp_odd.size() == 0) begin
            ok = 1'b1;
            break;
         end
         @(posedge clk);
      end
      repeat (3) @(posedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({v_n, d_n, pe_n, fe_n, ov_n} !== 12'h000) begin
         errors++;
         $display("FAIL reset_none got=%h exp=000", {v_n, d_n, pe_n, fe_n, ov_n});
      end
      checks++;
      if ({v_e, d_e, pe_e, fe_e, ov_e} !== 12'h000) begin
         errors++;
         $display("FAIL reset_even got=%h exp=000", {v_e, d_e, pe_e, fe_e, ov_e});
      end
      checks++;
      if ({v_o, d_o, pe_o, fe_o, ov_o} !== 12'h000) begin
         errors++;
         $display("FAIL reset_odd got=%h exp=000", {v_o, d_o, pe_o, fe_o, ov_o});
      end
      rst = 1'b0;
      repeat (20) @(posedge clk);
      #1;
      checks++;
      if ({v_n, v_e, v_o} !== 3'b000) begin
         errors++;
         $display("FAIL idle_after_reset valid=%b exp=000", {v_n, v_e, v_o});
      end
   endtask

   task automatic test_basic();
      int  lat, vcnt, w0, o0;
      bit  ok;
      sel = 0;
      rdy_none = 1'b1;
      w0 = words_none;
      o0 = ovr_none;
      lat = 0;
      vcnt = 0;
      @(posedge clk);
      #1;
      exp_none.push_back({1'b0, 1'b0, 8'hA5});
      fork
         send_frame(8'hA5, 1'b0, 1'b0, 1'b1, BIT_NS);
         begin
            for (int n = 1; n <= 200; n++) begin
               @(posedge clk);
               #1;
               if (v_n) begin
                  vcnt++;
                  if (lat == 0) lat = n;
               end
            end
         end
      join
      wait_drain(ok);
      checks++;
      if (lat < 97 || lat > 99) begin
         errors++;
         $display("FAIL basic_latency got=%0d exp=97..99", lat);
      end
      checks++;
      if (vcnt != 1) begin
         errors++;
         $display("FAIL basic_valid_cycles got=%0d exp=1", vcnt);
      end
      checks++;
      if (words_none - w0 != 1) begin
         errors++;
         $display("FAIL basic_words got=%0d exp=1", words_none - w0);
      end
      checks++;
      if (ovr_none != o0) begin
         errors++;
         $display("FAIL basic_ovr got=%0d exp=%0d", ovr_none, o0);
      end
   endtask

   task automatic test_parity();
      logic [7:0] d;
      logic       p;
      bit         ok;
      sel = 1;
      exp_even.push_back({1'b0, 1'b0, 8'h03});
      send_frame(8'h03, 1'b1, 1'b0, 1'b1, BIT_NS);
      exp_even.push_back({1'b0, 1'b1, 8'h03});
      send_frame(8'h03, 1'b1, 1'b1, 1'b1, BIT_NS);
      for (int i = 0; i < 6; i++) begin
         d = 8'($urandom_range(0, 255));
         p = 1'($urandom_range(0, 1));
         exp_even.push_back({1'b0, (p != ^d), d});
         send_frame(d, 1'b1, p, 1'b1, BIT_NS);
      end
      sel = 2;
      exp_odd.push_back({1'b0, 1'b0, 8'h01});
      send_frame(8'h01, 1'b1, 1'b0, 1'b1, BIT_NS);
      exp_odd.push_back({1'b0, 1'b1, 8'h01});
      send_frame(8'h01, 1'b1, 1'b1, 1'b1, BIT_NS);
      for (int i = 0; i < 6; i++) begin
         d = 8'($urandom_range(0, 255));
         p = 1'($urandom_range(0, 1));
         exp_odd.push_back({1'b0, (p != ~^d), d});
         send_frame(d, 1'b1, p, 1'b1, BIT_NS);
      end
      wait_drain(ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL parity_drain left even=%0d odd=%0d exp=0", exp_even.size(), exp_odd.size());
      end
      sel = 0;
   endtask

   task automatic test_glitch_break();
      int w0, vcnt;
      bit ok;
      sel = 0;
      rdy_none = 1'b1;
      w0 = words_none;
      vcnt = 0;
      @(posedge clk);
      #1;
      line = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      line = 1'b1;
      for (int n = 0; n < 40; n++) begin
         @(posedge clk);
         #1;
         if (v_n) vcnt++;
      end
      checks++;
      if (vcnt != 0 || words_none != w0) begin
         errors++;
         $display("FAIL glitch_ignored valid_cycles=%0d words=%0d exp=0", vcnt, words_none - w0);
      end
      exp_none.push_back({1'b1, 1'b0, 8'h00});
      line = 1'b0;
      #(20.0 * BIT_NS);
      line = 1'b1;
      repeat (40) @(posedge clk);
      checks++;
      if (words_none - w0 != 1) begin
         errors++;
         $display("FAIL break_one_word got=%0d exp=1", words_none - w0);
      end
      exp_none.push_back({1'b0, 1'b0, 8'h3C});
      send_frame(8'h3C, 1'b0, 1'b0, 1'b1, BIT_NS);
      wait_drain(ok);
      checks++;
      if (!ok || words_none - w0 != 2) begin
         errors++;
         $display("FAIL after_break words=%0d exp=2", words_none - w0);
      end
   endtask

   task automatic test_overrun();
      int o0;
      bit ok;
      sel = 0;
      rdy_none = 1'b0;
      o0 = ovr_none;
      exp_none.push_back({1'b0, 1'b0, 8'h22});
      send_frame(8'h11, 1'b0, 1'b0, 1'b1, BIT_NS);
      #1;
      checks++;
      if (v_n !== 1'b1 || d_n !== 8'h11 || ovr_none != o0) begin
         errors++;
         $display("FAIL ovr_first got v=%b d=%h ovr=%0d exp v=1 d=11 ovr=0", v_n, d_n, ovr_none - o0);
      end
      send_frame(8'h22, 1'b0, 1'b0, 1'b1, BIT_NS);
      repeat (20) @(posedge clk);
      #1;
      checks++;
      if (v_n !== 1'b1 || d_n !== 8'h22) begin
         errors++;
         $display("FAIL ovr_held got v=%b d=%h exp v=1 d=22", v_n, d_n);
      end
      checks++;
      if (ovr_none - o0 != 1) begin
         errors++;
         $display("FAIL ovr_pulses got=%0d exp=1", ovr_none - o0);
      end
      rdy_none = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (v_n !== 1'b0) begin
         errors++;
         $display("FAIL ovr_valid_drop got=%b exp=0", v_n);
      end
      wait_drain(ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL ovr_drain left=%0d exp=0", exp_none.size());
      end
   endtask

   task automatic test_reset_mid_frame();
      int w0, vcnt;
      bit ok;
      sel = 0;
      rdy_none = 1'b0;
      send_frame(8'h33, 1'b0, 1'b0, 1'b1, BIT_NS);
      #1;
      checks++;
      if (v_n !== 1'b1 || d_n !== 8'h33) begin
         errors++;
         $display("FAIL rstmid_pending got v=%b d=%h exp v=1 d=33", v_n, d_n);
      end
      fork
         send_frame(8'hFE, 1'b0, 1'b0, 1'b1, BIT_NS);
         begin
            #(4.5 * BIT_NS);
            @(posedge clk);
            #1;
            rst = 1'b1;
            @(posedge clk);
            #1;
            checks++;
            if ({v_n, d_n, pe_n, fe_n, ov_n} !== 12'h000) begin
               errors++;
               $display("FAIL rstmid_outputs got=%h exp=000", {v_n, d_n, pe_n, fe_n, ov_n});
            end
            rst = 1'b0;
         end
      join
      w0 = words_none;
      rdy_none = 1'b1;
      vcnt = 0;
      for (int n = 0; n < 60; n++) begin
         @(posedge clk);
         #1;
         if (v_n) vcnt++;
      end
      checks++;
      if (vcnt != 0 || words_none != w0) begin
         errors++;
         $display("FAIL rstmid_no_word valid_cycles=%0d exp=0", vcnt);
      end
      exp_none.push_back({1'b0, 1'b0, 8'h5A});
      send_frame(8'h5A, 1'b0, 1'b0, 1'b1, BIT_NS);
      wait_drain(ok);
      checks++;
      if (!ok || words_none - w0 != 1) begin
         errors++;
         $display("FAIL rstmid_next words=%0d exp=1", words_none - w0);
      end
   endtask

   task automatic test_baud_tolerance();
      logic [7:0] d;
      real        bns;
      int         o0;
      bit         ok;
      sel = 0;
      rdy_none = 1'b1;
      o0 = ovr_none;
      for (int r = 0; r < 2; r++) begin
         bns = (r == 0) ? BIT_NS / 1.03 : BIT_NS / 0.97;
         for (int i = 0; i < 16; i++) begin
            d = 8'($urandom_range(0, 255));
            exp_none.push_back({1'b0, 1'b0, d});
            send_frame(d, 1'b0, 1'b0, 1'b1, bns);
         end
         wait_drain(ok);
         checks++;
         if (!ok) begin
            errors++;
            $display("FAIL baud_drain rate=%0d left=%0d exp=0", r, exp_none.size());
         end
      end
      checks++;
      if (ovr_none != o0) begin
         errors++;
         $display("FAIL baud_ovr got=%0d exp=0", ovr_none - o0);
      end
   endtask

   initial begin
      fork
         monitor();
      join_none
      test_reset();
      test_basic();
      test_parity();
      test_glitch_break();
      test_overrun();
      test_reset_mid_frame();
      test_baud_tolerance();
      checks++;
      if (exp_none.size() != 0 || exp_even.size() != 0 || exp_odd.size() != 0) begin
         errors++;
         $display("FAIL final_queues none=%0d even=%0d odd=%0d exp=0",
                  exp_none.size(), exp_even.size(), exp_odd.size());
      end
      checks++;
      if (ovr_par != 0) begin
         errors++;
         $display("FAIL parity_ovr got=%0d exp=0", ovr_par);
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
